sequenciador_banco: RTL and testbench

Multicycle instruction sequencer that drives the 8×16-bit register bank `banco` as its sole client. It accepts one 16-bit instruction through a valid/ready handshake and generates the bank read and write addresses. It captures the two read operands, computes a 16-bit ALU result and writes it back through the bank's write port. It sits between an instruction source (test driver or fetch unit) and `banco`, making the bank usable as a tiny three-operand datapath.

---
 rtl/sequenciador_banco.sv | 173 +++++++++++++++++
 tb/tb_sequenciador_banco.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequenciador_banco.sv
// sequenciador_banco: four-cycle instruction sequencer for the 8x16 register
// bank "banco". Accepts one instruction per handshake, reads two operands,
// computes an ALU result and writes it back through the bank write port.
module sequenciador_banco (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [2:0]  Read1Add,
  output logic [2:0]  Read2Add,
  output logic [2:0]  WriteAdd,
  output logic [15:0] entrada,
  output logic        RW,
  input  logic [15:0] dado1,
  input  logic [15:0] dado2,
  output logic        done,
  output logic [15:0] resultado,
  output logic        zero,
  output logic        erro
);

  localparam logic [1:0] OCIOSO  = 2'd0;
  localparam logic [1:0] LEITURA = 2'd1;
  localparam logic [1:0] EXECUTA = 2'd2;
  localparam logic [1:0] ESCRITA = 2'd3;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_MOV = 4'd7;
  localparam logic [3:0] OP_LI  = 4'd8;
  localparam logic [3:0] OP_NOP = 4'd9;

  logic [1:0]  state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] op1_q, op1_d;
  logic [15:0] op2_q, op2_d;
  logic [15:0] alu_q, alu_d;
  logic [15:0] resultado_q, resultado_d;
  logic        zero_q, zero_d;

  // Instruction fields, all taken from the latched word
  logic [3:0]  op;
  logic [2:0]  rd;
  logic [2:0]  rs1;
  logic [2:0]  rs2;
  logic [8:0]  imm9;
  logic        escreve;
  logic        ilegal;
  logic        accept;

  assign op      = instr_q[15:12];
  assign rd      = instr_q[11:9];
  assign rs1     = instr_q[8:6];
  assign rs2     = instr_q[5:3];
  assign imm9    = instr_q[8:0];
  assign escreve = (op <= OP_LI);
  assign ilegal  = (op > OP_NOP);

  assign instr_ready = (state_q == OCIOSO) && reset_n;
  assign accept      = instr_ready && instr_valid;

  // Next-state sequencing: fixed four-state ring, leaving idle only on accept
  always_comb begin
    state_d = state_q;
    case (state_q)
      OCIOSO:  if (accept) state_d = LEITURA;
      LEITURA: state_d = EXECUTA;
      EXECUTA: state_d = ESCRITA;
      ESCRITA: state_d = OCIOSO;
      default: state_d = OCIOSO;
    endcase
  end

  // Instruction latch and operand capture
  always_comb begin
    instr_d = instr_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    if (accept) begin
      instr_d = instr;
    end
    if (state_q == LEITURA) begin
      op1_d = dado1;
      op2_d = dado2;
    end
  end

  // ALU evaluated once, in EXECUTA, from the captured operands
  always_comb begin
    alu_d = alu_q;
    if (state_q == EXECUTA) begin
      case (op)
        OP_ADD:  alu_d = op1_q + op2_q;
        OP_SUB:  alu_d = op1_q - op2_q;
        OP_AND:  alu_d = op1_q & op2_q;
        OP_OR:   alu_d = op1_q | op2_q;
        OP_XOR:  alu_d = op1_q ^ op2_q;
        OP_SHL:  alu_d = op1_q << op2_q[3:0];
        OP_SHR:  alu_d = op1_q >> op2_q[3:0];
        OP_MOV:  alu_d = op1_q;
        OP_LI:   alu_d = {{7{imm9[8]}}, imm9};
        default: alu_d = '0;
      endcase
    end
  end

  // Visible result and zero flag follow only real bank writes
  always_comb begin
    resultado_d = resultado_q;
    zero_d      = zero_q;
    if ((state_q == ESCRITA) && escreve) begin
      resultado_d = alu_q;
      zero_d      = (alu_q == 16'h0000);
    end
  end

  // Bank-facing outputs: addresses and data are zero outside their states;
  // RW/done are gated by reset_n so a reset in ESCRITA cancels the write
  always_comb begin
    Read1Add = '0;
    Read2Add = '0;
    WriteAdd = '0;
    entrada  = '0;
    RW       = 1'b0;
    done     = 1'b0;
    erro     = 1'b0;
    case (state_q)
      LEITURA: begin
        Read1Add = rs1;
        Read2Add = rs2;
      end
      ESCRITA: begin
        WriteAdd = rd;
        entrada  = alu_q;
        RW       = escreve && reset_n;
        done     = reset_n;
        erro     = ilegal && reset_n;
      end
      default: ;
    endcase
  end

  assign resultado = resultado_q;
  assign zero      = zero_q;

  // State registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= OCIOSO;
      instr_q     <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      alu_q       <= '0;
      resultado_q <= '0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      alu_q       <= alu_d;
      resultado_q <= resultado_d;
      zero_q      <= zero_d;
    end
  end

endmodule

// File: tb/tb_sequenciador_banco.sv
// Testbench for sequenciador_banco: models the register bank, drives directed
// and random instructions, and checks every phase against a reference model.
module tb_sequenciador_banco;

  logic        clock;
  logic        reset_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  Read1Add, Read2Add, WriteAdd;
  logic [15:0] entrada;
  logic        RW;
  logic [15:0] dado1, dado2;
  logic        done;
  logic [15:0] resultado;
  logic        zero;
  logic        erro;

  sequenciador_banco dut (
    .clock(clock), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .Read1Add(Read1Add), .Read2Add(Read2Add),
    .WriteAdd(WriteAdd), .entrada(entrada), .RW(RW), .dado1(dado1),
    .dado2(dado2), .done(done), .resultado(resultado), .zero(zero), .erro(erro)
  );

  // Bank environment: combinational reads, write on rising edge when RW
  logic [15:0] bank [8];
  assign dado1 = bank[Read1Add];
  assign dado2 = bank[Read2Add];
  always @(posedge clock) if (RW) bank[WriteAdd] <= entrada;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state
  logic [15:0] ref_regs [8];
  logic [15:0] ref_res;
  logic        ref_zero;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int rs2);
    return 16'(op * 4096 + rd * 512 + rs1 * 64 + rs2 * 8);
  endfunction

  function automatic logic [15:0] enc_li(input int rd, input int value);
    return 16'(8 * 4096 + rd * 512 + (value & 511));
  endfunction

  // Result of an instruction as plain arithmetic on operand values
  function automatic logic [15:0] ref_alu(input logic [15:0] ins, input logic [15:0] a, input logic [15:0] b);
    int unsigned sh;
    int unsigned imm;
    sh  = b % 16;
    imm = ins % 512;
    case (ins / 4096)
      0: return 16'((a + b) % 65536);
      1: return 16'((a + 65536 - b) % 65536);
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return 16'((a * (2 ** sh)) % 65536);
      6: return 16'(a / (2 ** sh));
      7: return a;
      8: return (imm >= 256) ? 16'(65536 - 512 + imm) : 16'(imm);
      default: return 16'h0000;
    endcase
  endfunction

  // Issues one instruction and checks every cycle until back in idle
  task automatic do_instr(input logic [15:0] ins, input bit keep_valid, output int acc);
    int op, rd, rs1, rs2;
    logic [15:0] exp;
    bit wr, ill, got;
    op  = ins / 4096;
    rd  = (ins / 512) % 8;
    rs1 = (ins / 64) % 8;
    rs2 = (ins / 8) % 8;
    instr = ins;
    instr_valid = 1'b1;
    got = 0;
    acc = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (instr_ready) begin got = 1; break; end
    end
    if (!got) begin
      chk("accept_timeout", 16'd0, 16'd1);
      instr_valid = 1'b0;
      return;
    end
    @(posedge clock); #1;
    acc = cyc;
    instr = 16'($urandom);
    instr_valid = keep_valid;
    exp = ref_alu(ins, ref_regs[rs1], ref_regs[rs2]);
    wr  = (op <= 8);
    ill = (op >= 10);
    // LEITURA
    chk("rd_ready", 16'(instr_ready), 16'd0);
    chk("rd_RW", 16'(RW), 16'd0);
    chk("rd_done", 16'(done), 16'd0);
    chk("rd_Read1Add", 16'(Read1Add), 16'(rs1));
    chk("rd_Read2Add", 16'(Read2Add), 16'(rs2));
    chk("rd_WriteAdd", 16'(WriteAdd), 16'd0);
    @(posedge clock); #1;
    // EXECUTA
    chk("ex_ready", 16'(instr_ready), 16'd0);
    chk("ex_RW", 16'(RW), 16'd0);
    chk("ex_done", 16'(done), 16'd0);
    chk("ex_Read1Add", 16'(Read1Add), 16'd0);
    @(posedge clock); #1;
    // ESCRITA
    chk("wr_ready", 16'(instr_ready), 16'd0);
    chk("wr_RW", 16'(RW), 16'(wr));
    chk("wr_WriteAdd", 16'(WriteAdd), 16'(rd));
    chk("wr_done", 16'(done), 16'd1);
    chk("wr_erro", 16'(erro), 16'(ill));
    chk("wr_Read1Add", 16'(Read1Add), 16'd0);
    if (wr) chk("wr_entrada", entrada, exp);
    if (wr) begin
      ref_regs[rd] = exp;
      ref_res      = exp;
      ref_zero     = (exp == 16'h0000);
    end
    @(posedge clock); #1;
    // back in OCIOSO
    chk("id_done", 16'(done), 16'd0);
    chk("id_erro", 16'(erro), 16'd0);
    chk("id_RW", 16'(RW), 16'd0);
    chk("id_ready", 16'(instr_ready), 16'd1);
    chk("id_resultado", resultado, ref_res);
    chk("id_zero", 16'(zero), 16'(ref_zero));
    chk("id_bank_rd", bank[rd], ref_regs[rd]);
  endtask

  // Reset for n cycles with instr_valid high, to show reset wins over accept
  task automatic do_reset(input int n);
    reset_n = 1'b0;
    instr = 16'h8205;
    instr_valid = 1'b1;
    repeat (n) begin
      @(posedge clock); #1;
      chk("rst_ready", 16'(instr_ready), 16'd0);
      chk("rst_RW", 16'(RW), 16'd0);
      chk("rst_done", 16'(done), 16'd0);
      chk("rst_erro", 16'(erro), 16'd0);
      chk("rst_addr", 16'({Read1Add, Read2Add, WriteAdd}), 16'd0);
      chk("rst_entrada", entrada, 16'd0);
      chk("rst_resultado", resultado, 16'd0);
      chk("rst_zero", 16'(zero), 16'd0);
    end
    reset_n = 1'b1;
    instr_valid = 1'b0;
    ref_res  = 16'h0000;
    ref_zero = 1'b0;
    #1;
    chk("rel_ready", 16'(instr_ready), 16'd1);
  endtask

  // Accepts an instruction, then resets it after 'depth' edges (2=EXECUTA, 3=ESCRITA)
  task automatic abort_instr(input logic [15:0] ins, input int depth);
    bit got;
    instr = ins;
    instr_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (instr_ready) begin got = 1; break; end
    end
    if (!got) chk("abort_accept_timeout", 16'd0, 16'd1);
    @(posedge clock); #1;
    instr_valid = 1'b0;
    repeat (depth - 1) begin @(posedge clock); #1; end
    reset_n = 1'b0;
    #1;
    chk("abort_RW", 16'(RW), 16'd0);
    chk("abort_done", 16'(done), 16'd0);
    chk("abort_ready", 16'(instr_ready), 16'd0);
    @(posedge clock); #1;
    chk("abort_done2", 16'(done), 16'd0);
    chk("abort_resultado", resultado, 16'd0);
    reset_n = 1'b1;
    ref_res  = 16'h0000;
    ref_zero = 1'b0;
    @(posedge clock); #1;
    chk("abort_rel_ready", 16'(instr_ready), 16'd1);
    chk("abort_bank_r7", bank[7], ref_regs[7]);
  endtask

  initial begin
    int a0, a1, a2, prev;
    logic [15:0] ins;
    logic [15:0] hold_res;
    logic        hold_zero;
    reset_n = 1'b0;
    instr = '0;
    instr_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bank[i]     = 16'($urandom);
      ref_regs[i] = bank[i];
    end
    ref_res = '0;
    ref_zero = 1'b0;
    @(posedge clock); #1;
    do_reset(3);

    do_instr(16'h8205, 0, a0);
    chk("li_r1_res", resultado, 16'h0005);
    do_instr(16'h85FD, 0, a0);
    chk("li_r2_bank", bank[2], 16'hFFFD);
    do_instr(16'h0650, 0, a0);
    chk("add_res", resultado, 16'h0002);
    do_instr(16'h1848, 0, a0);
    chk("sub_res", resultado, 16'h0000);
    chk("sub_zero", 16'(zero), 16'd1);

    // Build r1 = 0x8001 and r5 = 17, then shift
    do_instr(enc_li(1, 1), 0, a0);
    do_instr(enc_li(2, 15), 0, a0);
    do_instr(enc(5, 1, 1, 2), 0, a0);
    do_instr(enc_li(3, 1), 0, a0);
    do_instr(enc(3, 1, 1, 3), 0, a0);
    chk("r1_8001", bank[1], 16'h8001);
    do_instr(enc_li(5, 17), 0, a0);
    do_instr(16'h5C68, 0, a0);
    chk("shl_res", resultado, 16'h0002);
    do_instr(16'h6C68, 0, a0);
    chk("shr_res", resultado, 16'h4000);

    // Back-to-back with instr_valid held high
    do_instr(enc(0, 3, 1, 5), 1, a0);
    do_instr(enc(4, 4, 3, 1), 1, a1);
    do_instr(enc(7, 0, 4, 0), 0, a2);
    chk("b2b_gap1", 16'(a1 - a0), 16'd4);
    chk("b2b_gap2", 16'(a2 - a1), 16'd4);

    // NOP and illegal: no write, result held
    hold_res = resultado;
    hold_zero = zero;
    do_instr(16'h9E00, 0, a0);
    do_instr(16'hFE00, 0, a0);
    chk("nop_ill_res", resultado, hold_res);
    chk("nop_ill_zero", 16'(zero), 16'(hold_zero));

    // Reset in EXECUTA and ESCRITA of LI r7,0x0AA
    do_instr(enc_li(7, -1), 0, a0);
    abort_instr(16'h8EAA, 2);
    abort_instr(16'h8EAA, 3);
    do_instr(enc(7, 6, 7, 0), 0, a0);
    chk("r7_readback", resultado, 16'hFFFF);

    // Random instructions, valid held high between them
    prev = -1;
    for (int i = 0; i < 40; i++) begin
      ins = 16'($urandom);
      do_instr(ins, (i != 39), a0);
      if (prev >= 0) chk("rand_gap", 16'(a0 - prev), 16'd4);
      prev = a0;
    end
    for (int i = 0; i < 8; i++) chk("final_bank", bank[i], ref_regs[i]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
